// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-low segment patterns for hex digits,
// digit count and the blank (all-off) levels for the segment and anode lines.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] BLANK_SEG = 8'hFF;
    localparam logic [3:0] BLANK_AN  = 4'hF;

    // Index k holds the active-low {a,b,c,d,e,f,g} pattern that displays hex digit k.
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // True when exactly one bit of an active-low anode vector is asserted.
    function automatic logic single_anode(input logic [3:0] an_n);
        logic [3:0] sel;
        sel = ~an_n;
        return (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/seven_seg_pattern_decode.sv
// Combinational reverse lookup of a 7-bit active-low segment pattern to its hex nibble.
module seven_seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       hit_o
);

    always_comb begin
        nibble_o = 4'd0;
        hit_o    = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (pattern_i == SEG_PATTERNS[k]) begin
                nibble_o = 4'(k);
                hit_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Observes a multiplexed seven-segment display, debounces each scan slot and
// recovers the displayed 4-digit hex value with per-digit valid/error flags.
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_n,
    input  logic [3:0]  an_n,
    output logic [15:0] value,
    output logic [3:0]  digit_valid,
    output logic [3:0]  digit_err,
    output logic        frame_valid
);

    logic [7:0]  seg_q;
    logic [3:0]  an_q;
    logic [11:0] prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  err_q, err_d;
    logic [3:0]  seen_q, seen_d;
    logic        frame_q, frame_d;

    logic [11:0] sample;
    logic        same;
    logic        capture;
    logic [3:0]  nibble;
    logic        hit;

    assign sample = {an_q, seg_q};
    assign same   = (sample == prev_q);

    // cnt_q counts matching sample pairs since the last change, so it reads
    // STABLE_CYCLES-2 while the newest sample completes a run of STABLE_CYCLES.
    assign capture = same && (cnt_q == 8'(STABLE_CYCLES - 2)) && single_anode(an_q);

    seven_seg_pattern_decode u_decode (
        .pattern_i (seg_q[7:1]),
        .nibble_o  (nibble),
        .hit_o     (hit)
    );

    always_comb begin
        value_d = value_q;
        valid_d = valid_q;
        err_d   = err_q;
        seen_d  = seen_q;
        frame_d = 1'b0;
        cnt_d   = !same ? 8'd0 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);

        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (!an_q[i]) begin
                    if (hit) begin
                        value_d[4*i +: 4] = nibble;
                    end
                    valid_d[i] = hit;
                    err_d[i]   = !hit;
                    seen_d[i]  = 1'b1;
                end
            end
            if (seen_d == 4'hF) begin
                frame_d = 1'b1;
                seen_d  = 4'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q   <= BLANK_SEG;
            an_q    <= BLANK_AN;
            prev_q  <= {BLANK_AN, BLANK_SEG};
            cnt_q   <= 8'd0;
            value_q <= 16'd0;
            valid_q <= 4'd0;
            err_q   <= 4'd0;
            seen_q  <= 4'd0;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_n;
            an_q    <= an_n;
            prev_q  <= sample;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
            frame_q <= frame_d;
        end
    end

    assign value       = value_q;
    assign digit_valid = valid_q;
    assign digit_err   = err_q;
    assign frame_valid = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder: a history-based reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_seven_seg_scan_decoder;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  seg_n = 8'hFF;
    logic [3:0]  an_n = 4'hF;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_err;
    logic        frame_valid;

    int tests = 0;
    int fails = 0;
    int frame_cnt = 0;

    seven_seg_scan_decoder #(.STABLE_CYCLES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .value       (value),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0]  tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic [11:0] hist [$];
    logic [15:0] m_value;
    logic [3:0]  m_valid, m_err, m_seen;
    logic        m_frame;

    // A capture happens on the edge after the newest N samples agree and the
    // sample before them differs; the register reloads all-ones on reset.
    always @(posedge clk) begin
        if (rst) begin
            hist = {};
            hist.push_back(12'hFFF);
            m_value = 16'h0;
            m_valid = 4'h0;
            m_err   = 4'h0;
            m_seen  = 4'h0;
            m_frame = 1'b0;
        end else begin
            int sz;
            logic run;
            logic [11:0] s;
            m_frame = 1'b0;
            sz = hist.size();
            if (sz >= N + 1) begin
                s   = hist[sz-1];
                run = (hist[sz-N-1] != s);
                for (int k = 1; k <= N; k++) if (hist[sz-k] != s) run = 1'b0;
                if (run && $countones(~s[11:8]) == 1) begin
                    int d;
                    int found;
                    d = 0;
                    for (int k = 0; k < 4; k++) if (!s[8+k]) d = k;
                    found = -1;
                    for (int k = 0; k < 16; k++) if (tbl[k] == s[7:1]) found = k;
                    if (found >= 0) begin
                        m_value[4*d +: 4] = 4'(found);
                        m_valid[d] = 1'b1;
                        m_err[d]   = 1'b0;
                    end else begin
                        m_valid[d] = 1'b0;
                        m_err[d]   = 1'b1;
                    end
                    m_seen[d] = 1'b1;
                    if (m_seen == 4'hF) begin
                        m_frame = 1'b1;
                        m_seen  = 4'h0;
                    end
                end
            end
            hist.push_back({an_n, seg_n});
            if (hist.size() > 64) void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        check("model_value", 32'(value), 32'(m_value));
        check("model_valid", 32'(digit_valid), 32'(m_valid));
        check("model_err", 32'(digit_err), 32'(m_err));
        check("model_frame", 32'(frame_valid), 32'(m_frame));
        if (frame_valid) frame_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
        an_n  = an;
        seg_n = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        an_n  = 4'hF;
        seg_n = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check("reset_value", 32'(value), 32'h0);
        check("reset_valid", 32'(digit_valid), 32'h0);
        check("reset_err", 32'(digit_err), 32'h0);
        check("reset_frame", 32'(frame_valid), 32'h0);

        // Latency: capture lands exactly N+1 edges after the change
        an_n = 4'b1110; seg_n = 8'h24;
        repeat (N) @(negedge clk);
        check("lat_before_value", 32'(value[3:0]), 32'h0);
        check("lat_before_valid", 32'(digit_valid), 32'h0);
        @(negedge clk);
        check("lat_at_value", 32'(value[3:0]), 32'h2);
        check("lat_at_valid", 32'(digit_valid), 32'b0001);
        repeat (3) @(negedge clk);
        hold(4'hF, 8'hFF, 5);

        // Full scan after a fresh reset
        do_reset();
        frame_cnt = 0;
        hold(4'b1110, 8'h9E, 20);
        hold(4'b1101, 8'h24, 20);
        hold(4'b1011, 8'h0C, 20);
        check("scan_no_early_frame", 32'(frame_cnt), 32'd0);
        hold(4'b0111, 8'h98, 20);
        check("scan_value", 32'(value), 32'h4321);
        check("scan_valid", 32'(digit_valid), 32'hF);
        check("scan_frames", 32'(frame_cnt), 32'd1);

        // Too-short hold: no capture
        hold(4'b1110, 8'h24, 10);
        hold(4'hF, 8'hFF, 20);
        check("short_value", 32'(value), 32'h4321);
        check("short_valid", 32'(digit_valid), 32'hF);

        // Unknown pattern on digit 1
        hold(4'b1101, 8'hFE, 20);
        check("bad_err", 32'(digit_err), 32'b0010);
        check("bad_valid", 32'(digit_valid), 32'b1101);
        check("bad_value", 32'(value), 32'h4321);

        // Multiple anodes / blank ignored; dp ignored
        hold(4'b1100, 8'h24, 50);
        hold(4'b1111, 8'h24, 50);
        check("ignore_value", 32'(value), 32'h4321);
        check("ignore_err", 32'(digit_err), 32'b0010);
        hold(4'b1110, 8'h03, 20);
        check("dp_value", 32'(value), 32'h4320);
        check("dp_valid", 32'(digit_valid), 32'b1101);

        // Reset mid-frame discards progress
        frame_cnt = 0;
        hold(4'b1110, 8'h9E, 20);
        hold(4'b1101, 8'h9E, 20);
        hold(4'b1011, 8'h9E, 20);
        do_reset();
        hold(4'b1110, 8'h24, 20);
        hold(4'b1101, 8'h24, 20);
        hold(4'b1011, 8'h24, 20);
        check("rst_no_frame", 32'(frame_cnt), 32'd0);
        hold(4'b0111, 8'h24, 20);
        check("rst_one_frame", 32'(frame_cnt), 32'd1);
        check("rst_value", 32'(value), 32'h2222);
        hold(4'hF, 8'hFF, 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_decoder.md
SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: consecutive identical samples required before a digit is captured (legal range 2..255).
REQ-002 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port seg_n, input, 8: observed segment lines, active-low; [7]=a .. [1]=g, [0]=dp.
REQ-005 SHALL have port an_n, input, 4: observed digit anodes, active-low; an_n[i] low selects digit i.
REQ-006 SHALL have port value, output, 16: decoded hex value; digit i occupies value[4i+3:4i].
REQ-007 SHALL have port digit_valid, output, 4: bit i set when digit i's last capture matched the table.
REQ-008 SHALL have port digit_err, output, 4: bit i set when digit i's last capture matched no table entry.
REQ-009 SHALL have port frame_valid, output, 1: one-cycle pulse when all four digits have been captured since the previous pulse or reset.

Function
REQ-010 SHALL register seg_n and an_n in one input sample stage before any comparison.
REQ-011 SHALL keep an 8-bit saturating stability counter: cleared when the sampled {an_n,seg_n} differs from the previous sample, else incremented.
REQ-012 SHALL capture exactly once per stable interval, on the edge at which the sample has been identical for STABLE_CYCLES consecutive samples; input-change-to-output latency is STABLE_CYCLES+1 cycles.
REQ-013 SHALL ignore an_n values without exactly one low bit (1111 blank, or several low): no capture, no flag change; counter operates normally.
REQ-014 SHALL decode seg_n[7:1] only; seg_n[0] (dp) is ignored.
REQ-015 SHALL use decode table seg_n[7:1] -> nibble: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->b, 0110001->C, 1000010->d, 0110000->E, 0111000->F.
REQ-016 On a matching capture for digit i: value nibble i updated, digit_valid[i]=1, digit_err[i]=0.
REQ-017 On a non-matching capture for digit i: value nibble i unchanged, digit_valid[i]=0, digit_err[i]=1.
REQ-018 SHALL maintain a 4-bit seen mask; every capture (match or not) sets bit i; repeated captures of the same digit within a frame overwrite data and leave the mask unchanged.
REQ-019 When a capture completes the mask to 1111: frame_valid=1 for the following cycle only, mask cleared on the same edge.
REQ-020 value/digit_valid/digit_err hold between captures; frame_valid is 0 except per REQ-019.

Reset
REQ-021 On rst: value=0, digit_valid=0, digit_err=0, frame_valid=0, seen mask=0, stability counter=0, sample registers=all ones (inactive).
REQ-022 Reset mid-frame SHALL discard partial frame progress; frame_valid requires four fresh digit captures afterward.
REQ-023 First capture after reset SHALL need a full STABLE_CYCLES stable interval.

Structure
REQ-024 Package seven_seg_pkg SHALL hold the 16 segment-pattern constants (shared with the encoder side), digit count (4) and blank pattern.
REQ-025 Sub-module seven_seg_pattern_decode SHALL implement REQ-015 combinationally: 7-bit pattern in, 4-bit nibble and hit flag out.

Verification
REQ-026 an_n=1110, seg_n=0x24 held 20 cycles, STABLE_CYCLES=16 -> value[3:0]=2, digit_valid=0001, exactly STABLE_CYCLES+1 cycles after the change.
REQ-027 Scan digits 0..3 with seg_n 0x9E,0x24,0x0C,0x98, 20 cycles each -> value=0x4321, digit_valid=1111, one frame_valid pulse after the fourth capture.
REQ-028 Pattern held 10 cycles then changed (STABLE_CYCLES=16) -> no capture, outputs unchanged.
REQ-029 an_n=1101, seg_n=0xFE for 20 cycles -> digit_err[1]=1, digit_valid[1]=0, value[7:4] unchanged.
REQ-030 an_n=1100 or 1111 for 50 cycles -> no output change; seg_n=0x03 on digit 0 -> nibble 0 (dp ignored).
REQ-031 Three digits captured, rst pulsed, then four digits captured -> frame_valid only after the post-reset fourth capture.
